// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM encoding and byte-merge helper for the data cache.
package dcache_pkg;
    localparam int OFFSET_W = 3;
    localparam int DATA_W   = 64;
    localparam int BE_W     = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    // Overlay the enabled bytes of new_data onto old_data.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_data;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) r[i*8 +: 8] = new_data[i*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dcache_assoc_if.sv
// dcache_assoc_if: CPU-side and memory-side buses of the data cache.
//   cpu_*    : request/response from the processor (slave side of the cache)
//   mem_*    : writeback/fill requests to the next memory level
//   hit_cnt, miss_cnt : saturating access statistics
//   slave modport = cache view, master modport = CPU/memory environment view
interface dcache_assoc_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
        output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ack,
        input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache - valid/dirty/tag/data arrays plus hit compare.
//   index      : set being read (and written when we=1)
//   lookup_tag : tag compared against the stored tag for hit
//   we, wr_tag, wr_data, wr_dirty : install/update the line at index (sets valid)
//   hit, valid, dirty, tag, data  : state of the line at index
module dcache_way
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   lookup_tag,
    input  logic               we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_dirty,
    output logic               hit,
    output logic               valid,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag,
    output logic [DATA_W-1:0]  data
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= wr_dirty;
        end

    // Tag and data storage carry no reset; valid gates their use.
    always_ff @(posedge clk)
        if (we) begin
            tag_q[index]  <= wr_tag;
            data_q[index] <= wr_data;
        end

    assign valid = valid_q[index];
    assign dirty = valid_q[index] && dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];
    assign hit   = valid && (tag == lookup_tag);
endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative write-back, write-allocate data cache.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dcache_assoc_if.slave - CPU request/response, memory WB/FILL port, hit/miss counters
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 5
) (
    input logic           clk,
    input logic           rst,
    dcache_assoc_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;

    state_t state, next_state;

    logic [TAG_W-1:0]   req_tag, l_tag;
    logic [INDEX_W-1:0] req_idx, l_idx, idx;
    logic               l_we;
    logic [DATA_W-1:0]  l_wdata;
    logic [BE_W-1:0]    l_be;
    logic               vway, vway_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [SETS-1:0]    mru;
    logic [31:0]        hit_cnt, miss_cnt;
    logic               idle, sample, fill, hit_any;

    logic [1:0]         hit, valid, dirty, we;
    logic [TAG_W-1:0]   tag  [2];
    logic [DATA_W-1:0]  data [2];
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_dirty;
    logic               unused_offset;

    assign req_tag       = bus.cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign req_idx       = bus.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

    assign idle    = (state == IDLE);
    assign sample  = idle && bus.cpu_req;
    assign fill    = (state == FILL) && bus.mem_ack;
    assign hit_any = |hit;
    // Lookups use the live request in IDLE, the latched index afterwards.
    assign idx     = idle ? req_idx : l_idx;

    // First invalid way (way0 first), otherwise the way that is not MRU.
    assign vway = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : !mru[idx];

    // A way is written on a store hit in IDLE, or when its fill data returns.
    assign we       = ({2{sample & bus.cpu_we}} & hit) | ({2{fill}} & {vway_q, !vway_q});
    assign wr_tag   = idle ? req_tag : l_tag;
    assign wr_dirty = idle || l_we;
    assign wr_data  = idle ? byte_merge(data[hit[1]], bus.cpu_wdata, bus.cpu_be)
                    : l_we ? byte_merge(bus.mem_rdata, l_wdata, l_be)
                    : bus.mem_rdata;

    genvar w;
    generate
        for (w = 0; w < 2; w++) begin : g_way
            dcache_way #(
                .INDEX_W (INDEX_W),
                .TAG_W   (TAG_W)
            ) u_way (
                .clk        (clk),
                .rst        (rst),
                .index      (idx),
                .lookup_tag (req_tag),
                .we         (we[w]),
                .wr_tag     (wr_tag),
                .wr_data    (wr_data),
                .wr_dirty   (wr_dirty),
                .hit        (hit[w]),
                .valid      (valid[w]),
                .dirty      (dirty[w]),
                .tag        (tag[w]),
                .data       (data[w])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.cpu_req) next_state = hit_any ? RESP : dirty[vway] ? WB : FILL;
            WB:      if (bus.mem_ack) next_state = FILL;
            FILL:    if (bus.mem_ack) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // Memory outputs are decoded from state so a reset drops them at once;
    // the victim way and latched index keep them stable until mem_ack.
    assign bus.cpu_ready = (state == RESP);
    assign bus.cpu_rdata = (state == RESP) ? rdata_q : '0;
    assign bus.mem_req   = (state == WB) || (state == FILL);
    assign bus.mem_we    = (state == WB);
    assign bus.mem_addr  = (state == WB)   ? {tag[vway_q], l_idx, {OFFSET_W{1'b0}}}
                         : (state == FILL) ? {l_tag, l_idx, {OFFSET_W{1'b0}}}
                         : '0;
    assign bus.mem_wdata = (state == WB) ? data[vway_q] : '0;
    assign bus.hit_cnt   = hit_cnt;
    assign bus.miss_cnt  = miss_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mru      <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (sample && hit_any) mru[idx] <= hit[1];
            if (fill) mru[idx] <= vway_q;
            if (sample && hit_any && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (sample && !hit_any && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end

    always_ff @(posedge clk)
        if (sample) begin
            l_tag   <= req_tag;
            l_idx   <= req_idx;
            l_we    <= bus.cpu_we;
            l_wdata <= bus.cpu_wdata;
            l_be    <= bus.cpu_be;
            vway_q  <= vway;
            rdata_q <= bus.cpu_we ? '0 : data[hit[1]];
        end else if (fill) begin
            rdata_q <= l_we ? '0 : bus.mem_rdata;
        end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: scoreboard bench for dcache_assoc with a scripted memory responder.
module tb_dcache_assoc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_assoc_if #(.ADDR_W(32)) bus ();

    dcache_assoc #(.ADDR_W(32), .INDEX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
    } mem_t;

    mem_t        mem_q[$];
    logic [63:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail(string name);
        total++;
        $display("FAIL %s: event did not occur", name);
    endfunction

    function automatic void push_mem(logic we, logic [31:0] addr, logic [63:0] wd, logic [63:0] rd, int delay);
        mem_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rd; e.delay = delay;
        mem_q.push_back(e);
    endfunction

    // CPU response monitor: every ready pulse is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (bus.cpu_ready) begin
            if (exp_q.size() == 0) fail("unexpected_cpu_ready");
            else chk("cpu_rdata", bus.cpu_rdata, exp_q.pop_front());
        end
    end

    // Memory responder: checks each request, holds it for delay cycles, then acks.
    // delay < 0 means never ack (used to abandon a writeback with reset).
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (mem_q.size() == 0) begin
                    fail("unexpected_mem_req");
                    bus.mem_ack = 1'b1;
                    @(negedge clk);
                    bus.mem_ack = 1'b0;
                end else begin
                    mem_t e;
                    logic [31:0] a0;
                    logic w0, stable, rdy;
                    e = mem_q.pop_front();
                    chk("mem_we", bus.mem_we, e.we);
                    chk("mem_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                    a0 = bus.mem_addr; w0 = bus.mem_we; stable = 1'b1; rdy = 1'b0;
                    if (e.delay < 0) begin
                        for (int i = 0; i < 1000 && bus.mem_req; i++) @(negedge clk);
                    end else begin
                        for (int i = 0; i < e.delay; i++) begin
                            @(negedge clk);
                            if (!bus.mem_req || bus.mem_addr !== a0 || bus.mem_we !== w0) stable = 1'b0;
                            if (bus.cpu_ready) rdy = 1'b1;
                        end
                        if (e.delay > 0) begin
                            chk("mem_stable_while_waiting", stable, 1'b1);
                            chk("no_ready_while_waiting", rdy, 1'b0);
                        end
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = e.rdata;
                        @(negedge clk);
                        bus.mem_ack   = 1'b0;
                        bus.mem_rdata = '0;
                    end
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] be, input logic [63:0] exp, input bit exp_hit);
        int n;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wdata = wd; bus.cpu_be = be;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n = 1;
        while (!bus.cpu_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cpu_ready) fail("cpu_ready_timeout");
        else if (exp_hit) chk("hit_latency", n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_be = '0;
        #1;
        chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 64'h0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_hit_cnt", bus.hit_cnt, 0);
        chk("rst_miss_cnt", bus.miss_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Cold load fills, repeat load hits one cycle later.
        push_mem(1'b0, 32'h100, 64'h0, 64'hAAAA, 0);
        access(1'b0, 32'h100, 64'h0, 8'h00, 64'hAAAA, 1'b0);
        access(1'b0, 32'h100, 64'h0, 8'h00, 64'hAAAA, 1'b1);
        chk("miss_cnt_after_first", bus.miss_cnt, 1);
        chk("hit_cnt_after_first", bus.hit_cnt, 1);

        // Partial store over an all-ones line.
        access(1'b1, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1);
        access(1'b1, 32'h100, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b1);
        access(1'b0, 32'h100, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b1);

        // Store miss into the same set merges over fill data; then a third tag
        // evicts the dirty non-MRU line 0x100.
        push_mem(1'b0, 32'h2100, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
        access(1'b1, 32'h2100, 64'hDEAD_BEEF_0000_2100, 8'hF0, 64'h0, 1'b0);
        push_mem(1'b1, 32'h100, 64'hFFFF_FFFF_5566_7788, 64'h0, 2);
        push_mem(1'b0, 32'h4100, 64'h0, 64'h4100_4100_4100_4100, 0);
        access(1'b0, 32'h4100, 64'h0, 8'h00, 64'h4100_4100_4100_4100, 1'b0);
        access(1'b0, 32'h2100, 64'h0, 8'h00, 64'hDEAD_BEEF_89AB_CDEF, 1'b1);
        chk("hit_cnt_after_evict", bus.hit_cnt, 5);
        chk("miss_cnt_after_evict", bus.miss_cnt, 3);

        // Long fill wait with stray cpu_req pulses that must be ignored.
        push_mem(1'b0, 32'h308, 64'h0, 64'h3080_3080_3080_3080, 50);
        fork
            access(1'b0, 32'h308, 64'h0, 8'h00, 64'h3080_3080_3080_3080, 1'b0);
            begin
                repeat (5) @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    #1;
                    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
                    bus.cpu_addr = 32'h500 + 32'(i * 8); bus.cpu_be = 8'hFF;
                    @(posedge clk); #1;
                    bus.cpu_req = 1'b0;
                    @(posedge clk);
                end
            end
        join
        chk("miss_cnt_after_wait", bus.miss_cnt, 4);
        chk("hit_cnt_after_wait", bus.hit_cnt, 5);

        // Build a dirty victim in set 2, start its writeback, reset mid-WB.
        push_mem(1'b0, 32'h410, 64'h0, 64'h0, 0);
        access(1'b1, 32'h410, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 1'b0);
        push_mem(1'b0, 32'h2410, 64'h0, 64'h2410, 0);
        access(1'b0, 32'h2410, 64'h0, 8'h00, 64'h2410, 1'b0);
        push_mem(1'b1, 32'h410, 64'h5555_5555_5555_5555, 64'h0, -1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h4410;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 100 && !bus.mem_req; i++) @(negedge clk);
        if (!bus.mem_req) fail("wb_start");
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midwb_rst_mem_req", bus.mem_req, 1'b0);
        chk("midwb_rst_mem_addr", bus.mem_addr, 32'h0);
        chk("midwb_rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("midwb_rst_hit_cnt", bus.hit_cnt, 0);
        chk("midwb_rst_miss_cnt", bus.miss_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Valid bits were cleared: the old address misses again.
        push_mem(1'b0, 32'h410, 64'h0, 64'h77, 0);
        access(1'b0, 32'h410, 64'h0, 8'h00, 64'h77, 1'b0);
        chk("post_rst_miss_cnt", bus.miss_cnt, 1);
        chk("post_rst_hit_cnt", bus.hit_cnt, 0);

        repeat (3) @(posedge clk);
        chk("mem_queue_drained", mem_q.size(), 0);
        chk("cpu_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter INDEX_W, default 5: set-index width; the cache SHALL have 2**INDEX_W sets.
REQ-003 Derived constants: OFFSET_W = 3 (one 64-bit word per line); TAG_W = ADDR_W - INDEX_W - 3; tag = addr[ADDR_W-1 : INDEX_W+3]; index = addr[INDEX_W+2 : 3].
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cpu_req  input  1  request valid; sampled only in IDLE.
REQ-007 cpu_we  input  1  1 = store, 0 = load.
REQ-008 cpu_addr  input  ADDR_W  byte address; bits [2:0] ignored.
REQ-009 cpu_wdata  input  64  store data, byte lanes aligned to the word.
REQ-010 cpu_be  input  8  store byte enables, any pattern legal.
REQ-011 cpu_ready  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  64  load data; valid while cpu_ready=1, otherwise 0.
REQ-013 mem_req  output  1  memory request, held until mem_ack.
REQ-014 mem_we  output  1  1 = writeback, 0 = fill.
REQ-015 mem_addr  output  ADDR_W  word-aligned memory address.
REQ-016 mem_wdata  output  64  writeback data.
REQ-017 mem_rdata  input  64  fill data; valid with mem_ack.
REQ-018 mem_ack  input  1  completes the current memory request.
REQ-019 hit_cnt  output  32  saturating count of hits.
REQ-020 miss_cnt  output  32  saturating count of misses.

Function
REQ-021 The cache SHALL be 2-way set-associative, write-back, write-allocate, with per-way valid, dirty, tag and 64-bit data, plus one MRU bit per set.
REQ-022 FSM states SHALL be IDLE, WB, FILL and RESP; there SHALL be no other states.
REQ-023 In IDLE with cpu_req=1, the block SHALL latch addr, we, wdata and be, then perform the tag compare in the same cycle.
REQ-024 Hit: next state RESP; cpu_ready SHALL assert exactly 1 cycle after the sampling edge.
REQ-025 Load hit: cpu_rdata SHALL equal the hit way's data.
REQ-026 Store hit: only enabled bytes SHALL be merged into the line; the line SHALL be marked dirty; cpu_rdata SHALL be 0.
REQ-027 Victim on a miss: the first invalid way (way0 first); if both ways are valid, the way that is not MRU.
REQ-028 Miss with a dirty victim: next state WB.
- mem_req=1, mem_we=1.
- mem_addr = {victim tag, index, 3'b0}; mem_wdata = victim data.
- On mem_ack, the next state SHALL be FILL.
REQ-029 Miss with a clean or invalid victim: next state FILL.
REQ-030 FILL: mem_req=1, mem_we=0, mem_addr = {latched tag, index, 3'b0}.
- On mem_ack, install mem_rdata into the victim: valid=1, tag updated.
- For a store, enabled bytes SHALL be merged over the fill data and dirty set to 1; for a load, dirty=0.
- Next state RESP.
REQ-031 Load-miss cpu_rdata in RESP SHALL equal the filled word.
REQ-032 RESP SHALL last one cycle, then return to IDLE.
- cpu_req in RESP or any non-IDLE state SHALL be ignored.
- Back-to-back requests are accepted from the cycle after RESP.
REQ-033 The MRU bit of the set SHALL point to the accessed way on every hit and every fill.
REQ-034 mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack; mem_ack outside WB/FILL SHALL be ignored; the wait for mem_ack is unbounded.
REQ-035 hit_cnt SHALL increment on each hit and miss_cnt on each miss, both at the IDLE sampling edge, saturating at 32'hFFFF_FFFF.
REQ-036 mem_req SHALL be 0 in IDLE and RESP; cpu_ready SHALL be 0 outside RESP.

Reset
REQ-037 On rst, asynchronously and regardless of state:
- FSM to IDLE.
- All valid, dirty and MRU bits cleared.
- cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt and miss_cnt all 0.
REQ-038 Data and tag arrays need not be cleared.
REQ-039 A reset during WB or FILL SHALL abandon the transaction with no cache update; dirty data in flight is lost.

Structure
REQ-040 Package dcache_pkg SHALL hold the state encoding, OFFSET_W=3, DATA_W=64 and the byte-merge function.
REQ-041 Sub-module dcache_way SHALL hold one way's valid, dirty, tag and data arrays with its hit compare; it SHALL be instantiated twice.

Verification
REQ-042 Load 0x100 when cold -> FILL at mem_addr 0x100; ack with 0xAAAA -> cpu_rdata=0xAAAA; repeat load -> hit, cpu_ready 1 cycle after request, miss_cnt=1, hit_cnt=1.
REQ-043 Store 0x100 with be=8'h0F and wdata=0x1122334455667788 over line 0xFFFFFFFFFFFFFFFF -> a later load returns 0xFFFFFFFF55667788.
REQ-044 Dirty lines at 0x100 and 0x2100 (same set), then load 0x4100 -> WB of the non-MRU line at its address with its data, then FILL 0x4100.
REQ-045 Hold mem_ack low for 50 cycles during FILL -> mem_req and mem_addr stable, cpu_ready stays 0, cpu_req pulses ignored.
REQ-046 Assert rst mid-WB -> mem_req drops immediately; after reset, a load of the old address misses.
